pipe_stall_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_fwd_unit.sv | 36 +++
 rtl/pipe_stall_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/forwarding controller:
//   state_e      sequencer states (RUN / MEM_WAIT / ERR)
//   FWD_*        operand select codes driven on fwda / fwdb
//   reg_hit()    "this stage writes a non-zero register equal to src"
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EALU = 2'd1;
  localparam logic [1:0] FWD_MALU = 2'd2;
  localparam logic [1:0] FWD_MMO  = 2'd3;

  // Register 0 is hard-wired to zero, so a write to it never produces a match.
  function automatic logic reg_hit(input logic       wreg,
                                   input logic [4:0] rn,
                                   input logic [4:0] src);
    return wreg && (rn != 5'd0) && (rn == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// ---------------------------------------------------------------------------
// pipe_fwd_unit
// Purely combinational forwarding compare for one ID-stage source operand.
// Ports:
//   src            in  5  ID-stage source register number
//   ewreg, em2reg  in  1  EX stage writes a register / is a load
//   ern            in  5  EX destination register
//   mwreg, mm2reg  in  1  MEM stage writes a register / is a load
//   mrn            in  5  MEM destination register
//   fwd_sel        out 2  FWD_RF / FWD_EALU / FWD_MALU / FWD_MMO
// ---------------------------------------------------------------------------
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  output logic [1:0] fwd_sel
);

  // The youngest producer wins: EX is checked before MEM. A load in EX has no
  // result yet, so it is excluded here and handled by the load-use stall.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_hit(ewreg & ~em2reg, ern, src)) begin
      fwd_sel = FWD_EALU;
    end else if (reg_hit(mwreg, mrn, src)) begin
      fwd_sel = mm2reg ? FWD_MMO : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
// registers. Decodes stage enables, flush/bubble controls and forwarding
// selects, and runs the data-memory request/acknowledge handshake with a
// timeout that parks the pipeline in a sticky error state.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   drs, drt                ID source registers; d_use_rs/d_use_rt mark real use
//   d_taken                 branch/jump resolved taken in ID
//   ewreg, em2reg, ern      EX stage write / load / destination
//   mwreg, mm2reg, mrn      MEM stage write / load / destination
//   mmem                    MEM stage holds a load or store
//   dmem_ack / dmem_req     data memory handshake
//   pc_en, fd_en, de_en, em_en   register load enables
//   fd_flush, de_bubble, mw_bubble  NOP insertion controls
//   fwda, fwdb              operand forwarding selects
//   mem_err                 sticky timeout error
//   stall_cycles            saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       drs,
  input  logic [4:0]       drt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             mmem,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             em_en,
  output logic             de_bubble,
  output logic             mw_bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               mem_err_q, mem_err_d;
  logic               load_use;

  // Forwarding is decoded in every state; the enables decide whether the
  // selected operand is actually captured.
  pipe_fwd_unit u_fwd_rs (
    .src     (drs),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mrn     (mrn),
    .fwd_sel (fwda)
  );

  pipe_fwd_unit u_fwd_rt (
    .src     (drt),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mrn     (mrn),
    .fwd_sel (fwdb)
  );

  // A load in EX whose result the ID instruction really needs cannot be
  // forwarded in time, so ID must wait one cycle.
  always_comb begin
    load_use = ewreg && em2reg && (ern != 5'd0) &&
               ((d_use_rs && (ern == drs)) || (d_use_rt && (ern == drt)));
  end

  // Next-state and output decode. A memory access that is not acknowledged
  // in RUN stalls the whole pipe in that same cycle, so the entry cycle looks
  // exactly like a MEM_WAIT cycle. The ack cycle in MEM_WAIT releases every
  // stage at once so MEM-WB captures the returned data.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    mem_err_d = mem_err_q;
    dmem_req  = 1'b0;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    mw_bubble = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req  = mmem;
        tmo_cnt_d = '0;
        if (mmem && !dmem_ack) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_en     = 1'b0;
          em_en     = 1'b0;
          mw_bubble = 1'b1;
          state_d   = MEM_WAIT;
        end else if (load_use) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
        end else if (d_taken) begin
          fd_flush  = 1'b1;
        end
      end

      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d   = RUN;
          tmo_cnt_d = '0;
        end else begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_en     = 1'b0;
          em_en     = 1'b0;
          mw_bubble = 1'b1;
          if (tmo_cnt_q == TMO_LAST) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end

      // ERR, and any corrupted encoding, freezes the pipe until reset.
      default: begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_en     = 1'b0;
        em_en     = 1'b0;
        state_d   = ERR;
        mem_err_d = 1'b1;
      end
    endcase
  end

  // Performance counter: counts every frozen-PC cycle outside ERR and sticks
  // at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q != ERR) && !pc_en && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State, timeout, error and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= RUN;
      tmo_cnt_q      <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the pipeline
// controller kept in this file.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int MT   = 16;
  localparam int CW   = 6;
  localparam int SMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] drs;
    logic [4:0] drt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic       d_taken;
    logic       ewreg;
    logic       em2reg;
    logic [4:0] ern;
    logic       mwreg;
    logic       mm2reg;
    logic [4:0] mrn;
    logic       mmem;
    logic       dmem_ack;
  } stim_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [4:0]    drs, drt, ern, mrn;
  logic          d_use_rs, d_use_rt, d_taken;
  logic          ewreg, em2reg, mwreg, mm2reg, mmem, dmem_ack;
  logic          dmem_req, pc_en, fd_en, fd_flush, de_en, em_en;
  logic          de_bubble, mw_bubble, mem_err;
  logic [1:0]    fwda, fwdb;
  logic [CW-1:0] stall_cycles;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  stim_t cur;

  // Behavioural model: is the pipe parked on an error, waiting on memory,
  // how many wait cycles have gone by, and how many stalls have been counted.
  bit    m_err;
  bit    m_waiting;
  int    m_waited;
  int    m_stalls;
  logic  exp_pc_last;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .drs          (drs),
    .drt          (drt),
    .d_use_rs     (d_use_rs),
    .d_use_rt     (d_use_rt),
    .d_taken      (d_taken),
    .ewreg        (ewreg),
    .em2reg       (em2reg),
    .ern          (ern),
    .mwreg        (mwreg),
    .mm2reg       (mm2reg),
    .mrn          (mrn),
    .mmem         (mmem),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .fd_flush     (fd_flush),
    .de_en        (de_en),
    .em_en        (em_en),
    .de_bubble    (de_bubble),
    .mw_bubble    (mw_bubble),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  // Keeps a broken design from hanging the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: summary not reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Expected forwarding select for one source register.
  function automatic logic [1:0] refFwd(input stim_t s, input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (s.ewreg && !s.em2reg && s.ern == src) return 2'd1;
    if (s.mwreg && s.mrn == src) return s.mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
  endtask

  task automatic applyStimulus(input stim_t s);
    cur      = s;
    drs      = s.drs;
    drt      = s.drt;
    d_use_rs = s.d_use_rs;
    d_use_rt = s.d_use_rt;
    d_taken  = s.d_taken;
    ewreg    = s.ewreg;
    em2reg   = s.em2reg;
    ern      = s.ern;
    mwreg    = s.mwreg;
    mm2reg   = s.mm2reg;
    mrn      = s.mrn;
    mmem     = s.mmem;
    dmem_ack = s.dmem_ack;
  endtask

  // Compares every output against what the model says for the current inputs.
  task automatic checkOutput();
    logic lu, req, pc, fd, fl, de, em, db, mb;
    lu = cur.ewreg && cur.em2reg && (cur.ern != 0) &&
         ((cur.d_use_rs && cur.ern == cur.drs) || (cur.d_use_rt && cur.ern == cur.drt));
    req = 0; pc = 1; fd = 1; de = 1; em = 1; fl = 0; db = 0; mb = 0;
    if (m_err) begin
      pc = 0; fd = 0; de = 0; em = 0;
    end else if (m_waiting && cur.dmem_ack) begin
      req = 1;
    end else if (m_waiting || (cur.mmem && !cur.dmem_ack)) begin
      req = 1; pc = 0; fd = 0; de = 0; em = 0; mb = 1;
    end else begin
      req = cur.mmem;
      if (lu) begin
        pc = 0; fd = 0; db = 1;
      end else begin
        fl = cur.d_taken;
      end
    end
    exp_pc_last = pc;
    chk("dmem_req", dmem_req, req);
    chk("pc_en", pc_en, pc);
    chk("fd_en", fd_en, fd);
    chk("fd_flush", fd_flush, fl);
    chk("de_en", de_en, de);
    chk("em_en", em_en, em);
    chk("de_bubble", de_bubble, db);
    chk("mw_bubble", mw_bubble, mb);
    chk("fwda", fwda, refFwd(cur, cur.drs));
    chk("fwdb", fwdb, refFwd(cur, cur.drt));
    chk("mem_err", mem_err, m_err);
    chk("stall_cycles", stall_cycles, m_stalls);
  endtask

  // Advances the model across the coming rising edge.
  task automatic modelStep();
    if (!m_err && !exp_pc_last && m_stalls < SMAX) m_stalls++;
    if (m_err) begin
      // parked until reset
    end else if (m_waiting) begin
      if (cur.dmem_ack) begin
        m_waiting = 0;
        m_waited  = 0;
      end else begin
        m_waited++;
        if (m_waited == MT) begin
          m_waiting = 0;
          m_err     = 1;
        end
      end
    end else if (cur.mmem && !cur.dmem_ack) begin
      m_waiting = 1;
      m_waited  = 0;
    end
  endtask

  task automatic runCycle(input stim_t s);
    @(negedge clk);
    applyStimulus(s);
    cyc++;
    #1;
    checkOutput();
    modelStep();
  endtask

  // Asserts reset at the current time (mid-cycle), checks, then releases it
  // on the next falling edge.
  task automatic doReset();
    applyStimulus(idleStim());
    resetn    = 1'b0;
    m_err     = 0;
    m_waiting = 0;
    m_waited  = 0;
    m_stalls  = 0;
    #1;
    checkOutput();
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_mem_err", mem_err, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput();
    chk("rst_release_pc_en", pc_en, 1);
  endtask

  initial begin
    stim_t s;
    int    reqHigh;
    int    ackPct;

    resetn = 1'b0;
    applyStimulus(idleStim());
    @(negedge clk);
    #2;
    doReset();

    // Load-use: one bubble cycle, then the load result comes from MEM.
    $display("[TB] load-use stall");
    s = idleStim();
    s.ewreg = 1; s.em2reg = 1; s.ern = 5'd3; s.d_use_rs = 1; s.drs = 5'd3;
    runCycle(s);
    chk("t1_pc_en", pc_en, 0);
    chk("t1_fd_en", fd_en, 0);
    chk("t1_de_bubble", de_bubble, 1);
    s = idleStim();
    s.mwreg = 1; s.mm2reg = 1; s.mrn = 5'd3; s.d_use_rs = 1; s.drs = 5'd3;
    runCycle(s);
    chk("t1_fwda", fwda, 3);
    chk("t1_pc_en_resume", pc_en, 1);

    // Forwarding priority and register 0.
    $display("[TB] forwarding");
    s = idleStim();
    s.ewreg = 1; s.ern = 5'd5; s.drt = 5'd5; s.d_use_rt = 1; s.mwreg = 1; s.mrn = 5'd5;
    runCycle(s);
    chk("t2_fwdb_ex_wins", fwdb, 1);
    s.ern = 5'd0; s.drt = 5'd0;
    runCycle(s);
    chk("t2_fwdb_r0", fwdb, 0);
    s = idleStim();
    s.mwreg = 1; s.mm2reg = 1; s.mrn = 5'd7; s.drt = 5'd7; s.drs = 5'd7;
    runCycle(s);
    chk("t2_fwdb_mmo", fwdb, 3);
    s.mm2reg = 0;
    runCycle(s);
    chk("t2_fwda_malu", fwda, 2);

    // Memory wait acknowledged after three cycles.
    $display("[TB] memory wait with ack");
    @(negedge clk);
    #2;
    doReset();
    reqHigh = 0;
    s = idleStim();
    s.mmem = 1;
    for (int i = 0; i < 4; i++) begin
      s.dmem_ack = (i == 3);
      runCycle(s);
      if (dmem_req) reqHigh++;
      if (i == 0) chk("t3_mw_bubble_entry", mw_bubble, 1);
    end
    runCycle(idleStim());
    chk("t3_req_cycles", reqHigh, 4);
    chk("t3_stall_cycles", stall_cycles, 3);

    // Memory timeout into ERR, then recovery by reset.
    $display("[TB] memory timeout");
    @(negedge clk);
    #2;
    doReset();
    s = idleStim();
    s.mmem = 1;
    for (int i = 0; i < MT + 1; i++) runCycle(s);
    chk("t4_no_err_yet", mem_err, 0);
    runCycle(s);
    chk("t4_mem_err", mem_err, 1);
    chk("t4_pc_en", pc_en, 0);
    chk("t4_em_en", em_en, 0);
    chk("t4_dmem_req", dmem_req, 0);
    chk("t4_stall_cycles", stall_cycles, MT + 1);
    s.dmem_ack = 1;
    runCycle(s);
    chk("t4_err_sticky", mem_err, 1);
    @(negedge clk);
    #2;
    doReset();

    // Branch flush yields to load-use.
    $display("[TB] branch flush priority");
    s = idleStim();
    s.d_taken = 1; s.ewreg = 1; s.em2reg = 1; s.ern = 5'd9; s.d_use_rt = 1; s.drt = 5'd9;
    runCycle(s);
    chk("t5_no_flush", fd_flush, 0);
    chk("t5_pc_en_stall", pc_en, 0);
    s = idleStim();
    s.d_taken = 1;
    runCycle(s);
    chk("t5_flush", fd_flush, 1);
    chk("t5_pc_en", pc_en, 1);

    // Reset in the second MEM_WAIT cycle.
    $display("[TB] reset during memory wait");
    @(negedge clk);
    #2;
    doReset();
    s = idleStim();
    s.mmem = 1;
    runCycle(s);
    runCycle(s);
    @(negedge clk);
    applyStimulus(s);
    cyc++;
    #1;
    checkOutput();
    chk("t6_req_before_reset", dmem_req, 1);
    #2;
    doReset();

    // Counter saturation under a long load-use stall.
    $display("[TB] stall counter saturation");
    s = idleStim();
    s.ewreg = 1; s.em2reg = 1; s.ern = 5'd4; s.d_use_rs = 1; s.drs = 5'd4;
    for (int i = 0; i < SMAX + 8; i++) runCycle(s);
    chk("t7_saturated", stall_cycles, SMAX);
    runCycle(s);
    runCycle(idleStim());
    chk("t7_no_wrap", stall_cycles, SMAX);
    @(negedge clk);
    #2;
    doReset();

    // Randomized run against the model.
    $display("[TB] random phase");
    for (int i = 0; i < 800; i++) begin
      ackPct = (i < 250) ? 50 : (i < 550) ? 6 : 30;
      s = idleStim();
      s.drs      = 5'($urandom_range(0, 3));
      s.drt      = 5'($urandom_range(0, 3));
      s.ern      = 5'($urandom_range(0, 3));
      s.mrn      = 5'($urandom_range(0, 3));
      s.d_use_rs = 1'($urandom_range(0, 1));
      s.d_use_rt = 1'($urandom_range(0, 1));
      s.d_taken  = ($urandom_range(0, 99) < 25);
      s.ewreg    = 1'($urandom_range(0, 1));
      s.em2reg   = 1'($urandom_range(0, 1));
      s.mwreg    = 1'($urandom_range(0, 1));
      s.mm2reg   = 1'($urandom_range(0, 1));
      s.mmem     = ($urandom_range(0, 99) < 40);
      s.dmem_ack = ($urandom_range(0, 99) < ackPct);
      if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        @(negedge clk);
        #2;
        doReset();
      end
      runCycle(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
